// File: rtl/perceptron_neuron_if.sv
// Bundle of the vector handshake, weight port and result signals of perceptron_neuron.
// master drives vectors/weights (source side); slave is the neuron itself.
interface perceptron_neuron_if #(
    parameter int N_INPUTS = 4,
    parameter int Q_M      = 15,
    parameter int Q_N      = 16
) ();
    localparam int W     = 1 + Q_M + Q_N;
    localparam int AW    = $clog2(N_INPUTS + 1);
    localparam int ACC_W = W + AW;

    logic                x_valid_in;
    logic                x_ready_out;
    logic [N_INPUTS-1:0] x_in;
    logic                train_in;
    logic                target_in;
    logic                w_we_in;
    logic [AW-1:0]       w_addr_in;
    logic [W-1:0]        w_data_in;
    logic [W-1:0]        w_rdata_out;
    logic                y_out;
    logic [ACC_W-1:0]    sum_out;
    logic                y_valid_out;
    logic                busy_out;

    modport master (
        output x_valid_in, x_in, train_in, target_in,
        output w_we_in, w_addr_in, w_data_in,
        input  x_ready_out, w_rdata_out,
        input  y_out, sum_out, y_valid_out, busy_out
    );

    modport slave (
        input  x_valid_in, x_in, train_in, target_in,
        input  w_we_in, w_addr_in, w_data_in,
        output x_ready_out, w_rdata_out,
        output y_out, sum_out, y_valid_out, busy_out
    );
endinterface

// File: rtl/perceptron_neuron.sv
// Trainable N-input perceptron: sequential MAC, step activation, in-place learning rule.
// Ports: clk_i, rst_ni (sync, active-low), bus (perceptron_neuron_if.slave).
module perceptron_neuron #(
    parameter int N_INPUTS = 4,
    parameter int BIAS     = 1,
    parameter int Q_M      = 15,
    parameter int Q_N      = 16,
    parameter int LR_SHIFT = 4
) (
    input logic                clk_i,
    input logic                rst_ni,
    perceptron_neuron_if.slave bus
);
    localparam int W     = 1 + Q_M + Q_N;
    localparam int AW    = $clog2(N_INPUTS + 1);
    localparam int ACC_W = W + AW;
    localparam int NW    = N_INPUTS + 1;

    localparam logic              BIAS_BIT = (BIAS != 0);
    localparam logic signed [W:0] DELTA    = (W+1)'(1) << (Q_N - LR_SHIFT);
    localparam logic signed [W:0] SAT_HI   = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] SAT_LO   = -SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DECIDE,
        S_UPDATE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [W-1:0]     r_w [NW];
    logic [N_INPUTS:0]       r_xb;
    logic                    r_train;
    logic                    r_target;
    logic signed [ACC_W-1:0] r_acc;
    logic [AW-1:0]           r_idx;
    logic                    r_y;
    logic [ACC_W-1:0]        r_sum;
    logic                    r_valid;

    function automatic logic signed [W-1:0] sm2tc(input logic [W-1:0] v);
        logic signed [W-1:0] mag;
        mag = {1'b0, v[W-2:0]};
        return v[W-1] ? -mag : mag;
    endfunction

    function automatic logic [W-1:0] tc2sm(input logic signed [W-1:0] v);
        logic [W-1:0] mag;
        mag = v[W-1] ? -v : v;
        return {v[W-1], mag[W-2:0]};
    endfunction

    logic                    w_accept;
    logic                    w_addr_ok;
    logic                    w_wr_en;
    logic signed [W-1:0]     w_wr_tc;
    logic signed [W-1:0]     w_bias_now;
    logic signed [W-1:0]     w_cur;
    logic signed [ACC_W-1:0] w_wext;
    logic                    w_pos;
    logic signed [W:0]       w_sum_e;
    logic signed [W-1:0]     w_upd;

    assign w_accept  = bus.x_valid_in & bus.x_ready_out;
    assign w_addr_ok = {1'b0, bus.w_addr_in} < (AW+1)'(NW);
    assign w_wr_en   = bus.w_we_in & w_addr_ok & (r_state == S_IDLE);
    assign w_wr_tc   = sm2tc(bus.w_data_in);

    // A same-cycle write to the bias slot must feed the accumulator seed.
    assign w_bias_now = (w_wr_en && bus.w_addr_in == AW'(N_INPUTS))
                      ? w_wr_tc : r_w[N_INPUTS];

    assign w_cur   = r_w[r_idx];
    assign w_wext  = {{AW{w_cur[W-1]}}, w_cur};
    assign w_pos   = !r_acc[ACC_W-1] && (r_acc != '0);
    assign w_sum_e = {w_cur[W-1], w_cur} + (r_target ? DELTA : -DELTA);

    always_comb begin
        w_upd = w_sum_e[W-1:0];
        if (w_sum_e > SAT_HI) w_upd = SAT_HI[W-1:0];
        else if (w_sum_e < SAT_LO) w_upd = SAT_LO[W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ACCUM;
            S_ACCUM:  if (r_idx == AW'(N_INPUTS - 1)) w_next = S_DECIDE;
            S_DECIDE: w_next = (r_train && (w_pos != r_target)) ? S_UPDATE : S_IDLE;
            S_UPDATE: if (r_idx == AW'(N_INPUTS)) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NW; i++) r_w[i] <= '0;
            r_xb     <= '0;
            r_train  <= 1'b0;
            r_target <= 1'b0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_y      <= 1'b0;
            r_sum    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_wr_en) r_w[bus.w_addr_in] <= w_wr_tc;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Top bit of r_xb is the bias input so UPDATE indexes uniformly.
                        r_xb     <= {BIAS_BIT, bus.x_in};
                        r_train  <= bus.train_in;
                        r_target <= bus.target_in;
                        r_acc    <= BIAS_BIT ? {{AW{w_bias_now[W-1]}}, w_bias_now} : '0;
                        r_idx    <= '0;
                    end
                end
                S_ACCUM: begin
                    if (r_xb[r_idx]) r_acc <= r_acc + w_wext;
                    r_idx <= r_idx + AW'(1);
                end
                S_DECIDE: begin
                    r_y     <= w_pos;
                    r_sum   <= r_acc;
                    r_valid <= 1'b1;
                    r_idx   <= '0;
                end
                S_UPDATE: begin
                    if (r_xb[r_idx]) r_w[r_idx] <= w_upd;
                    r_idx <= r_idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.x_ready_out = rst_ni && (r_state == S_IDLE);
    assign bus.busy_out    = (r_state != S_IDLE);
    assign bus.y_out       = r_y;
    assign bus.sum_out     = r_sum;
    assign bus.y_valid_out = r_valid;
    assign bus.w_rdata_out = w_addr_ok ? tc2sm(r_w[w_addr_ok ? bus.w_addr_in : '0]) : '0;
endmodule

// File: tb/tb_perceptron_neuron.sv
// Scoreboard bench for perceptron_neuron (N_INPUTS=4, BIAS=1, Q15.16, LR_SHIFT=4).
// Stimulus pushes expected results; a negedge monitor pops and compares on y_valid_out.
module tb_perceptron_neuron;
    localparam int N     = 4;
    localparam int W     = 32;
    localparam int AW    = 3;
    localparam int ACC_W = 35;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    perceptron_neuron_if #(.N_INPUTS(N), .Q_M(15), .Q_N(16)) bus ();

    perceptron_neuron #(
        .N_INPUTS(N), .BIAS(1), .Q_M(15), .Q_N(16), .LR_SHIFT(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic             y;
        logic [ACC_W-1:0] sum;
        int               cyc;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.y_valid_out) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got y_valid at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_y"}, 64'(bus.y_out), 64'(e.y));
                chk({e.name, "_sum"}, 64'(bus.sum_out), 64'(e.sum));
                chk({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic write_w(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        bus.w_we_in   = 1'b1;
        bus.w_addr_in = a;
        bus.w_data_in = d;
        @(negedge clk);
        bus.w_we_in   = 1'b0;
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [W-1:0] exp, input string nm);
        @(negedge clk);
        bus.w_addr_in = a;
        #1;
        chk(nm, 64'(bus.w_rdata_out), 64'(exp));
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        @(negedge clk);
        while (!bus.x_ready_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.x_ready_out) chk({nm, "_ready_timeout"}, 64'(bus.x_ready_out), 64'd1);
    endtask

    task automatic wait_valid(input string nm, output logic rdy);
        int t = 0;
        rdy = 1'b0;
        @(negedge clk);
        while (!bus.y_valid_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.y_valid_out) chk({nm, "_valid_timeout"}, 64'(bus.y_valid_out), 64'd1);
        rdy = bus.x_ready_out;
    endtask

    // Returns in the first ACCUM cycle (negedge after the handshake edge).
    task automatic send(input logic [N-1:0] x, input logic tr, input logic tg,
                        input logic push, input logic ey,
                        input logic [ACC_W-1:0] es, input string nm);
        wait_idle(nm);
        bus.x_valid_in = 1'b1;
        bus.x_in       = x;
        bus.train_in   = tr;
        bus.target_in  = tg;
        if (push) exp_q.push_back('{ey, es, cyc + N + 2, nm});
        @(negedge clk);
        bus.x_valid_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic rdy;
        int   n;
        rst_n          = 1'b0;
        bus.x_valid_in = 1'b0;
        bus.x_in       = '0;
        bus.train_in   = 1'b0;
        bus.target_in  = 1'b0;
        bus.w_we_in    = 1'b0;
        bus.w_addr_in  = '0;
        bus.w_data_in  = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready_low", 64'(bus.x_ready_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(bus.x_ready_out), 64'd1);
        chk("rst_valid", 64'(bus.y_valid_out), 64'd0);
        chk("rst_busy", 64'(bus.busy_out), 64'd0);
        chk("rst_y", 64'(bus.y_out), 64'd0);
        chk("rst_sum", 64'(bus.sum_out), 64'd0);

        write_w(3'd6, 32'h0000_1234);
        for (int i = 0; i < 5; i++) read_chk(AW'(i), 32'h0, "rst_weight");
        read_chk(3'd6, 32'h0, "oob_read");

        send(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 35'h0, "zero_w");
        wait_valid("zero_w", rdy);
        chk("ready_with_valid", 64'(rdy), 64'd1);

        write_w(3'd0, 32'h0000_C76F);
        write_w(3'd1, 32'h0000_B23F);
        write_w(3'd4, 32'h8000_5363);
        read_chk(3'd4, 32'h8000_5363, "rb_bias_sm");
        read_chk(3'd0, 32'h0000_C76F, "rb_w0");
        send(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, -35'sh5363, "or_00");
        send(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 35'h740C, "or_01");
        send(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 35'h5EDC, "or_10");
        send(4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 35'h1264B, "or_11");
        wait_idle("or");

        for (int i = 0; i < 5; i++) write_w(AW'(i), 32'h0);
        send(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 35'h0, "train1");
        wait_valid("train1", rdy);
        n = 0;
        while (!bus.x_ready_out && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("train_busy_cycles", 64'(n), 64'd5);
        read_chk(3'd0, 32'h0000_1000, "train_w0");
        read_chk(3'd1, 32'h0, "train_w1");
        read_chk(3'd2, 32'h0, "train_w2");
        read_chk(3'd3, 32'h0, "train_w3");
        read_chk(3'd4, 32'h0000_1000, "train_wb");

        write_w(3'd0, 32'h7FFF_FFFF);
        write_w(3'd1, 32'hFFFF_FFFF);
        write_w(3'd4, 32'h0);
        read_chk(3'd1, 32'hFFFF_FFFF, "rb_negmax");
        send(4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 35'h0, "sat");
        wait_idle("sat");
        read_chk(3'd0, 32'h7FFF_FFFF, "sat_w0");
        read_chk(3'd1, 32'hFFFF_EFFF, "sat_w1");
        read_chk(3'd4, 32'h0000_1000, "sat_wb");
        read_chk(3'd2, 32'h0, "sat_w2");

        send(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 35'h8000_0FFF, "negdelta");
        wait_idle("negdelta");
        read_chk(3'd0, 32'h7FFF_EFFF, "neg_w0");
        read_chk(3'd4, 32'h0, "neg_wb");

        send(4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 35'h7FFF_EFFF, "match");
        wait_valid("match", rdy);
        chk("match_no_update_ready", 64'(rdy), 64'd1);
        read_chk(3'd0, 32'h7FFF_EFFF, "match_w0");

        send(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 35'h7FFF_EFFF, "gate");
        write_w(3'd1, 32'h0000_0055);
        wait_valid("gate", rdy);
        bus.w_we_in   = 1'b1;
        bus.w_addr_in = 3'd2;
        bus.w_data_in = 32'h0000_0066;
        @(negedge clk);
        bus.w_we_in   = 1'b0;
        wait_idle("gate");
        read_chk(3'd1, 32'hFFFF_EFFF, "gate_w1");
        read_chk(3'd2, 32'h0, "gate_w2");
        read_chk(3'd0, 32'h7FFF_DFFF, "gate_w0");
        read_chk(3'd4, 32'h8000_1000, "gate_wb");

        @(negedge clk);
        bus.w_we_in    = 1'b1;
        bus.w_addr_in  = 3'd4;
        bus.w_data_in  = 32'h0000_2000;
        bus.x_valid_in = 1'b1;
        bus.x_in       = 4'b0000;
        bus.train_in   = 1'b0;
        bus.target_in  = 1'b0;
        exp_q.push_back('{1'b1, 35'h2000, cyc + N + 2, "wr_hs"});
        @(negedge clk);
        bus.w_we_in    = 1'b0;
        bus.x_valid_in = 1'b0;
        wait_idle("wr_hs");
        read_chk(3'd4, 32'h0000_2000, "wr_hs_wb");

        send(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 35'h0, "midrst");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready_low", 64'(bus.x_ready_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(bus.x_ready_out), 64'd1);
        chk("midrst_busy", 64'(bus.busy_out), 64'd0);
        chk("midrst_y", 64'(bus.y_out), 64'd0);
        chk("midrst_sum", 64'(bus.sum_out), 64'd0);
        n = 0;
        repeat (10) begin
            if (bus.y_valid_out) n++;
            @(negedge clk);
        end
        chk("midrst_no_valid", 64'(n), 64'd0);
        for (int i = 0; i < 5; i++) read_chk(AW'(i), 32'h0, "midrst_weight");
        write_w(3'd2, 32'h0003_0000);
        send(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 35'h3_0000, "post_rst");
        wait_idle("post_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
